ptr_list_collector: RTL and testbench
=====================================

PTR_LIST_COLLECTOR -- requirements
Module: ptr_list_collector

Interface
REQ-001 The block SHALL have parameter n, default 16, number of list entries.
REQ-002 The block SHALL have parameter Width, default $clog2(n), pointer width.
REQ-003 The block SHALL have parameter Depth, default 4, summary FIFO depth (power of 2).
REQ-004 The block SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port in_ptr  input  Width  pointer beat from the upstream sequence generator.
REQ-007 The block SHALL have port in_ptr_vld  input  1  in_ptr is valid (no backpressure to upstream).
REQ-008 The block SHALL have port sum_head, sum_tail  output  Width each  first and last pointer of the oldest buffered list.
REQ-009 The block SHALL have port sum_len  output  Width+1  number of distinct entries in that list.
REQ-010 The block SHALL have port sum_chk  output  Width  XOR of all entries of that list (see Configuration).
REQ-011 The block SHALL have ports sum_vld  output  1 and sum_rdy  input  1, summary handshake.
REQ-012 The block SHALL have ports ovf  output  1 and err  output  1, sticky error flags.

Function
REQ-013 The collector SHALL have states IDLE and RUN.
REQ-014 IDLE, in_ptr_vld=1, in_ptr!=0: go to RUN; head=tail=in_ptr; len=1; chk=in_ptr.
REQ-015 RUN, in_ptr_vld=1, in_ptr!=tail: tail=in_ptr; len+1, saturating at 2^(Width+1)-1; chk^=in_ptr.
REQ-016 RUN, in_ptr_vld=1, in_ptr==tail: repeated beat, no state change.
REQ-017 RUN, in_ptr_vld=0 (cycle t): list closes; {head,tail,len,chk} pushes into FIFO at the edge ending t; go to IDLE.
REQ-018 The first beat of a new list SHALL be accepted in the cycle immediately after a close cycle.
REQ-019 A valid beat with in_ptr==0 in either state SHALL be ignored and SHALL set err.
REQ-020 The FIFO SHALL be registered with first-word-fall-through: a push into an empty FIFO at the end of cycle t gives sum_vld=1 in cycle t+1.
REQ-021 A pop SHALL occur on each cycle with sum_vld & sum_rdy; outputs SHALL hold stable while sum_vld=1 and sum_rdy=0.
REQ-022 Push when full with a pop in the same cycle SHALL succeed (count unchanged).
REQ-023 Push when full with no pop SHALL drop the summary, set ovf, and leave FIFO contents unchanged.
REQ-024 Read and write indices SHALL wrap modulo Depth; occupancy SHALL be a Width-independent $clog2(Depth)+1-bit counter.
REQ-025 sum_* data outputs SHALL be don't-care while sum_vld=0.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, empty FIFO, sum_vld=0, ovf=0, err=0, and internal head/tail/len/chk=0.
REQ-027 rst=1 mid-list SHALL discard the partial list; no summary is produced for it.
REQ-028 Inputs in the reset cycle SHALL be ignored; the first beat can be accepted in the cycle after rst deasserts.

Configuration
REQ-029 The block SHALL honour macro LIST_CHECKSUM_EN.
REQ-030 With LIST_CHECKSUM_EN defined, chk SHALL be accumulated and stored per REQ-014/015, and sum_chk SHALL carry it.
REQ-031 Without LIST_CHECKSUM_EN, no chk storage SHALL exist, and sum_chk SHALL be tied to 0; all other behaviour is identical.

Verification
REQ-032 Beats 7,7,7,15,15,15,8,8,8 then vld=0, sum_rdy=1 -> next cycle sum_vld=1, head=7, tail=8, len=3, chk=0.
REQ-033 Beats 9,14,11,13,12 then a gap -> head=9, tail=12, len=5, chk=13 (0 without LIST_CHECKSUM_EN).
REQ-034 sum_rdy=0 with 5 lists closed (1,5,3,10 / 2,4 / 6 / 7,15,8 / 9,14,11,13,12) -> first 4 buffered in order, 5th dropped, ovf=1; then sum_rdy=1 -> 4 pops, first head=1 len=4 chk=13.
REQ-035 FIFO full, list closes in a cycle with sum_rdy=1 -> pop and push both succeed, ovf stays 0.
REQ-036 rst pulsed after beats 9,14 -> no summary, sum_vld=0; next list 6 then gap -> head=tail=6, len=1.
REQ-037 Beat in_ptr=0 with vld=1 during RUN on list 2,4 -> err=1, summary head=2, tail=4, len=2.

Source files
------------

// File: rtl/ptr_list_collector.sv
// ptr_list_collector
//   Collects runs of pointer beats from an upstream sequence generator into
//   per-list summaries and buffers them in a small first-word-fall-through
//   FIFO for a downstream consumer.
//
//   A list opens on the first non-zero valid beat and extends on every valid
//   beat that differs from the current tail. Repeated beats are absorbed. The
//   list closes on the first cycle with in_ptr_vld low. A zero pointer is
//   never a legal entry: it is ignored and raises the sticky err flag.
//
//   Optional feature macro: LIST_CHECKSUM_EN
//     defined   : XOR checksum of the list entries is kept and reported
//     undefined : no checksum storage, sum_chk tied to 0
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   in_ptr     : pointer beat (Width bits)
//   in_ptr_vld : in_ptr valid, no backpressure
//   sum_head   : first pointer of the oldest buffered list
//   sum_tail   : last pointer of the oldest buffered list
//   sum_len    : entry count of that list (Width+1 bits, saturating)
//   sum_chk    : XOR of that list's entries, or 0 without the checksum
//   sum_vld    : summary available
//   sum_rdy    : consumer accepts the summary (pop on sum_vld & sum_rdy)
//   ovf        : sticky, a summary was dropped because the FIFO was full
//   err        : sticky, a valid zero pointer was seen
module ptr_list_collector #(
  parameter int n     = 16,
  parameter int Width = $clog2(n),
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] in_ptr,
  input  logic             in_ptr_vld,
  output logic [Width-1:0] sum_head,
  output logic [Width-1:0] sum_tail,
  output logic [Width:0]   sum_len,
  output logic [Width-1:0] sum_chk,
  output logic             sum_vld,
  input  logic             sum_rdy,
  output logic             ovf,
  output logic             err
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth) + 1;
  localparam int LW = Width + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [Width-1:0] head;
  logic [Width-1:0] tail;
  logic [LW-1:0]    len;
`ifdef LIST_CHECKSUM_EN
  logic [Width-1:0] chk;
  logic [Width-1:0] f_chk [Depth];
`endif

  logic [Width-1:0] f_head [Depth];
  logic [Width-1:0] f_tail [Depth];
  logic [LW-1:0]    f_len  [Depth];

  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [CW-1:0] count;

  logic close;
  logic pop;
  logic full;
  logic push_ok;
  logic beat_ok;

  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] i);
    return (i == AW'(Depth - 1)) ? '0 : i + AW'(1);
  endfunction

  always_comb begin
    beat_ok = in_ptr_vld && (in_ptr != '0);
    close   = (state == RUN) && !in_ptr_vld;
    pop     = (count != '0) && sum_rdy;
    full    = (count == CW'(Depth));
    // A full FIFO still accepts the push when the same edge frees a slot.
    push_ok = close && (!full || pop);
  end

  // Collector FSM, FIFO pointers and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      head   <= '0;
      tail   <= '0;
      len    <= '0;
`ifdef LIST_CHECKSUM_EN
      chk    <= '0;
`endif
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (in_ptr_vld && (in_ptr == '0)) err <= 1'b1;

      case (state)
        IDLE: begin
          if (beat_ok) begin
            state <= RUN;
            head  <= in_ptr;
            tail  <= in_ptr;
            len   <= LW'(1);
`ifdef LIST_CHECKSUM_EN
            chk   <= in_ptr;
`endif
          end
        end
        RUN: begin
          if (!in_ptr_vld) begin
            state <= IDLE;
          end else if (beat_ok && (in_ptr != tail)) begin
            tail <= in_ptr;
            if (len != '1) len <= len + LW'(1);
`ifdef LIST_CHECKSUM_EN
            chk  <= chk ^ in_ptr;
`endif
          end
        end
        default: state <= IDLE;
      endcase

      if (push_ok) wr_idx <= next_idx(wr_idx);
      if (pop)     rd_idx <= next_idx(rd_idx);
      if (close && full && !pop) ovf <= 1'b1;

      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Summary storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      f_head[wr_idx] <= head;
      f_tail[wr_idx] <= tail;
      f_len[wr_idx]  <= len;
`ifdef LIST_CHECKSUM_EN
      f_chk[wr_idx]  <= chk;
`endif
    end
  end

  always_comb begin
    sum_vld  = (count != '0);
    sum_head = f_head[rd_idx];
    sum_tail = f_tail[rd_idx];
    sum_len  = f_len[rd_idx];
`ifdef LIST_CHECKSUM_EN
    sum_chk  = f_chk[rd_idx];
`else
    sum_chk  = '0;
`endif
  end

endmodule

// File: tb/tb_ptr_list_collector.sv
// Testbench for ptr_list_collector: scoreboard of expected summaries,
// popped and compared by a monitor whenever the DUT hands one over.
module tb_ptr_list_collector;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [W:0]   len;
    logic [W-1:0] chk;
  } summary_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_ptr;
  logic         in_ptr_vld;
  logic [W-1:0] sum_head;
  logic [W-1:0] sum_tail;
  logic [W:0]   sum_len;
  logic [W-1:0] sum_chk;
  logic         sum_vld;
  logic         sum_rdy;
  logic         ovf;
  logic         err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  summary_t    exp_q[$];
  int unsigned stim[$];

  ptr_list_collector #(.n(16), .Width(W), .Depth(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_ptr     (in_ptr),
    .in_ptr_vld (in_ptr_vld),
    .sum_head   (sum_head),
    .sum_tail   (sum_tail),
    .sum_len    (sum_len),
    .sum_chk    (sum_chk),
    .sum_vld    (sum_vld),
    .sum_rdy    (sum_rdy),
    .ovf        (ovf),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected summary of the beats in stim, straight from the list rules.
  function automatic summary_t model();
    summary_t     s;
    logic [W-1:0] b;
    bit           open;
    s    = '0;
    open = 1'b0;
    foreach (stim[i]) begin
      b = W'(stim[i]);
      if (b == '0) continue;
      if (!open) begin
        open   = 1'b1;
        s.head = b;
        s.tail = b;
        s.len  = 1;
        s.chk  = b;
      end else if (b != s.tail) begin
        s.tail = b;
        if (s.len != '1) s.len = s.len + 1'b1;
        s.chk  = s.chk ^ b;
      end
    end
`ifndef LIST_CHECKSUM_EN
    s.chk = '0;
`endif
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beats();
    foreach (stim[i]) begin
      in_ptr     = W'(stim[i]);
      in_ptr_vld = 1'b1;
      step();
    end
  endtask

  task automatic close_list();
    in_ptr_vld = 1'b0;
    in_ptr     = '0;
    step();
  endtask

  task automatic send(input bit keep);
    if (keep) exp_q.push_back(model());
    drive_beats();
    close_list();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_ptr_vld = 1'b0;
    in_ptr     = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    check("drain", 32'(exp_q.size()), 0);
  endtask

  // Monitor: a pop happens at the next edge whenever sum_vld & sum_rdy.
  always @(negedge clk) begin
    if (!rst && sum_vld && sum_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 1, 0);
      end else begin
        summary_t e;
        e = exp_q.pop_front();
        check("head", 32'(sum_head), 32'(e.head));
        check("tail", 32'(sum_tail), 32'(e.tail));
        check("len",  32'(sum_len),  32'(e.len));
        check("chk",  32'(sum_chk),  32'(e.chk));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    in_ptr     = '0;
    in_ptr_vld = 1'b0;
    sum_rdy    = 1'b1;
    #1;
    step();
    step();
    // beat presented during the reset cycle must be ignored
    in_ptr     = 4'd5;
    in_ptr_vld = 1'b1;
    step();
    rst        = 1'b0;
    in_ptr_vld = 1'b0;
    in_ptr     = '0;
    @(negedge clk);
    check("rst_vld", 32'(sum_vld), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_err", 32'(err), 0);
    step();
    step();
    @(negedge clk);
    check("rst_beat_ignored", 32'(sum_vld), 0);
    step();

    // repeated beats collapse; summary visible the cycle after close
    stim = '{7, 7, 7, 15, 15, 15, 8, 8, 8};
    send(1'b1);
    @(negedge clk);
    check("fwft_vld", 32'(sum_vld), 1);
    step();
    drain();

    stim = '{9, 14, 11, 13, 12};
    send(1'b1);
    drain();

    // zero beat mid-list: ignored, err set
    stim = '{2, 0, 4};
    send(1'b1);
    drain();
    @(negedge clk);
    check("err_set", 32'(err), 1);
    check("ovf_clear", 32'(ovf), 0);
    step();

    // back-to-back lists, first beat right after the close cycle
    stim = '{3, 5};
    send(1'b1);
    stim = '{6};
    send(1'b1);
    stim = '{10, 11, 10};
    send(1'b1);
    drain();

    // length saturation: 40 alternating beats
    stim.delete();
    for (int i = 0; i < 40; i++) stim.push_back((i % 2 == 0) ? 1 : 2);
    send(1'b1);
    drain();

    // overflow: five lists with consumer stalled, fifth dropped
    sum_rdy = 1'b0;
    stim = '{1, 5, 3, 10};     send(1'b1);
    stim = '{2, 4};            send(1'b1);
    stim = '{6};               send(1'b1);
    stim = '{7, 15, 8};        send(1'b1);
    stim = '{9, 14, 11, 13, 12}; send(1'b0);
    @(negedge clk);
    check("ovf_set", 32'(ovf), 1);
    check("full_vld", 32'(sum_vld), 1);
    check("hold_head0", 32'(sum_head), 1);
    step();
    @(negedge clk);
    check("hold_head1", 32'(sum_head), 1);
    check("hold_len1", 32'(sum_len), 4);
    step();
    sum_rdy = 1'b1;
    drain();
    step();
    @(negedge clk);
    check("empty_vld", 32'(sum_vld), 0);
    step();

    // full FIFO, close coincides with a pop: no drop
    do_reset();
    sum_rdy = 1'b0;
    stim = '{1};    send(1'b1);
    stim = '{2};    send(1'b1);
    stim = '{3};    send(1'b1);
    stim = '{4};    send(1'b1);
    stim = '{5, 6};
    exp_q.push_back(model());
    drive_beats();
    sum_rdy = 1'b1;
    close_list();
    drain();
    @(negedge clk);
    check("no_ovf", 32'(ovf), 0);
    step();

    // reset mid-list discards it
    stim = '{9, 14};
    drive_beats();
    do_reset();
    @(negedge clk);
    check("mid_rst_vld", 32'(sum_vld), 0);
    check("mid_rst_err", 32'(err), 0);
    step();
    step();
    @(negedge clk);
    check("mid_rst_nosum", 32'(sum_vld), 0);
    step();
    stim = '{6};
    send(1'b1);
    drain();

    repeat (3) step();
    check("final_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
